video_pattern_axis_src: RTL and testbench

//  Downstream stage of the sync/timing generator. Consumes its active-window

---
 rtl/video_pkg.sv | 27 ++
 rtl/video_pattern_axis_src_if.sv | 13 +
 rtl/video_pattern_axis_src_fifo.sv | 45 ++++
 rtl/video_pattern_axis_src.sv | 149 ++++++++++++++
 tb/tb_video_pattern_axis_src.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/video_pkg.sv
// Shared types for the test-pattern video source: pattern selector,
// colour-bar levels and the flag half of a FIFO entry.
package video_pkg;

  typedef enum logic [1:0] {
    PAT_RAMP    = 2'd0,
    PAT_BARS    = 2'd1,
    PAT_CHECKER = 2'd2,
    PAT_FILL    = 2'd3
  } pattern_e;

  localparam int BAR_COUNT = 8;

  // Level of colour bar b: full scale of a pix_w-bit pixel times b/7.
  function automatic logic [31:0] bar_level(input int pix_w, input int b);
    logic [63:0] full;
    full = (64'd1 << pix_w) - 64'd1;
    return 32'((full * 64'(b)) / 64'd7);
  endfunction

  // A FIFO entry is {beat_flags_t, tdata}, flags in the top two bits.
  typedef struct packed {
    logic tuser;
    logic tlast;
  } beat_flags_t;

endpackage

// File: rtl/video_pattern_axis_src_if.sv
// AXI4-Stream video bus between the pattern source and its sink.
interface video_pattern_axis_src_if #(
  parameter int PIX_W = 16
);
  logic [PIX_W-1:0] tdata;
  logic             tvalid;
  logic             tready;
  logic             tuser;
  logic             tlast;

  modport master (output tdata, tvalid, tuser, tlast, input tready);
  modport slave  (input tdata, tvalid, tuser, tlast, output tready);
endinterface

// File: rtl/video_pattern_axis_src_fifo.sv
// First-word-fall-through synchronous FIFO with a flush input; a write into
// a full FIFO is only accepted when a read frees a slot in the same cycle.
module sync_fifo_fwft #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             do_rd, do_wr;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_rd   = rd_en & ~empty;
  assign do_wr   = wr_en & (~full | do_rd);
  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_wr) - (AW+1)'(do_rd);
    end
  end
endmodule

// File: rtl/video_pattern_axis_src.sv
// Test-pattern source: turns timing-generator strobes into an AXI4-Stream
// video stream, with a small FIFO to ride out sink backpressure.
module video_pattern_axis_src
  import video_pkg::*;
#(
  parameter int PIX_W      = 16,
  parameter int H_WIDTH    = 2448,
  parameter int V_WIDTH    = 2048,
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = 13
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        VSYNC,
  input  logic        HSYNC,
  input  logic [1:0]  pat_sel,
  input  logic        err_clr,
  video_pattern_axis_src_if.master m_axis,
  output logic [15:0] frame_cnt,
  output logic        overflow,
  output logic        line_err,
  output logic        frame_err
);
  localparam int ENTRY_W = PIX_W + 2;
  localparam int BAR_W   = (H_WIDTH / BAR_COUNT > 0) ? H_WIDTH / BAR_COUNT : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             vs_d, hs_d, vs_rise, vs_fall, hs_fall;
  logic [CNT_W-1:0] x, y;
  pattern_e         pat_lat;
  logic             sof_pend, hold_valid, hold_user;
  logic [PIX_W-1:0] hold_data, pixel;
  logic [2:0]       bar_idx;
  logic [PIX_W-1:0] bar_tbl [BAR_COUNT];
  beat_flags_t      wr_flags, rd_flags;
  logic             fifo_wr, fifo_rd, fifo_full, fifo_empty, drop;
  logic [ENTRY_W-1:0] fifo_rd_data;

  assign vs_rise = VSYNC & ~vs_d;
  assign vs_fall = ~VSYNC & vs_d;
  assign hs_fall = ~HSYNC & hs_d;

  for (genvar g = 0; g < BAR_COUNT; g++) begin : g_bar
    assign bar_tbl[g] = PIX_W'(bar_level(PIX_W, g));
  end

  // Bar index by threshold compare so no divider is needed; the last bar
  // absorbs whatever remains of the line.
  always_comb begin
    bar_idx = '0;
    for (int b = 1; b < BAR_COUNT; b++) begin
      if (32'(x) >= 32'(b * BAR_W)) bar_idx = 3'(b);
    end
  end

  always_comb begin
    pixel = '0;
    case (pat_lat)
      PAT_RAMP:    pixel = PIX_W'(32'(x) + 32'(y));
      PAT_BARS:    pixel = bar_tbl[bar_idx];
      PAT_CHECKER: pixel = (x[4] ^ y[4]) ? '1 : '0;
      PAT_FILL:    pixel = PIX_W'(frame_cnt);
      default:     pixel = '0;
    endcase
  end

  // Position counters and the one-beat hold register; the hold register is
  // pushed one clock later so the falling HSYNC can tag it as end-of-line.
  always_ff @(posedge clk) begin
    if (rst) begin
      vs_d       <= 1'b0;
      hs_d       <= 1'b0;
      x          <= '0;
      y          <= '0;
      frame_cnt  <= '0;
      sof_pend   <= 1'b0;
      pat_lat    <= PAT_RAMP;
      hold_valid <= 1'b0;
      hold_user  <= 1'b0;
      hold_data  <= '0;
    end else begin
      vs_d <= VSYNC;
      hs_d <= HSYNC;
      if (!enable) begin
        x          <= '0;
        y          <= '0;
        sof_pend   <= 1'b0;
        hold_valid <= 1'b0;
      end else begin
        hold_valid <= HSYNC;
        if (hs_fall) begin
          x <= '0;
          if (y != CNT_MAX) y <= y + CNT_W'(1);
        end
        if (vs_rise) begin
          y         <= '0;
          frame_cnt <= frame_cnt + 16'd1;
          sof_pend  <= 1'b1;
          pat_lat   <= pattern_e'(pat_sel);
        end
        if (HSYNC) begin
          hold_data <= pixel;
          hold_user <= sof_pend;
          sof_pend  <= 1'b0;
          if (x != CNT_MAX) x <= x + CNT_W'(1);
        end
      end
    end
  end

  assign fifo_wr  = enable & hold_valid;
  assign fifo_rd  = m_axis.tvalid & m_axis.tready;
  assign drop     = fifo_wr & fifo_full & ~fifo_rd;
  assign wr_flags = '{tuser: hold_user, tlast: ~HSYNC};

  // Sticky error flags: a new error in the clearing cycle keeps the flag set.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      line_err  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      overflow  <= drop | (overflow & ~err_clr);
      line_err  <= (enable & hs_fall & (x != CNT_W'(H_WIDTH))) | (line_err & ~err_clr);
      frame_err <= (enable & vs_fall & (y != CNT_W'(V_WIDTH))) | (frame_err & ~err_clr);
    end
  end

  sync_fifo_fwft #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush   (~enable),
    .wr_en   (fifo_wr),
    .wr_data ({wr_flags, hold_data}),
    .full    (fifo_full),
    .rd_en   (fifo_rd),
    .rd_data (fifo_rd_data),
    .empty   (fifo_empty)
  );

  assign {rd_flags, m_axis.tdata} = fifo_rd_data;
  assign m_axis.tuser  = rd_flags.tuser;
  assign m_axis.tlast  = rd_flags.tlast;
  assign m_axis.tvalid = ~fifo_empty;
endmodule

// File: tb/tb_video_pattern_axis_src.sv
// Bench for the pattern source: directed scenarios then random frames, all
// checked every cycle against a queue-based model of the emitted stream.
module tb_video_pattern_axis_src;
  localparam int PIX_W = 16;
  localparam int H     = 8;
  localparam int V     = 4;
  localparam int DEPTH = 16;
  localparam int CNT_W = 13;

  logic        clk = 1'b0;
  logic        rst, enable, VSYNC, HSYNC, err_clr;
  logic [1:0]  pat_sel;
  logic [15:0] frame_cnt;
  logic        overflow, line_err, frame_err;

  video_pattern_axis_src_if #(.PIX_W(PIX_W)) axis ();

  video_pattern_axis_src #(
    .PIX_W(PIX_W), .H_WIDTH(H), .V_WIDTH(V), .FIFO_DEPTH(DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .VSYNC     (VSYNC),
    .HSYNC     (HSYNC),
    .pat_sel   (pat_sel),
    .err_clr   (err_clr),
    .m_axis    (axis),
    .frame_cnt (frame_cnt),
    .overflow  (overflow),
    .line_err  (line_err),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic             user;
    logic             last;
    logic [PIX_W-1:0] data;
  } beat_t;

  // Model: the stream the sink should see, as a queue of accepted beats.
  beat_t       q[$];
  beat_t       pend;
  logic        pend_v;
  int          m_x, m_line, m_pat;
  int unsigned m_frames;
  logic        m_sof, m_vs_prev, m_hs_prev;
  logic        m_ovf, m_lerr, m_ferr;
  int          rdy_mode;
  logic        cur_vs;
  int          n_assert = 0;
  int          n_fail   = 0;

  function automatic logic [PIX_W-1:0] expPixel(input int pat, input int px, input int ln,
                                                input int unsigned frames);
    longint bar;
    case (pat)
      0: return PIX_W'(px + ln);
      1: begin
        bar = longint'(px / (H / 8));
        if (bar > 7) bar = 7;
        return PIX_W'(((longint'(1) << PIX_W) - 1) * bar / 7);
      end
      2: return ((((px >> 4) ^ (ln >> 4)) & 1) != 0) ? {PIX_W{1'b1}} : {PIX_W{1'b0}};
      default: return PIX_W'(frames);
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkState();
    checkOutput("tvalid", 32'(axis.tvalid), 32'(q.size() > 0));
    if (q.size() > 0) begin
      checkOutput("tdata", 32'(axis.tdata), 32'(q[0].data));
      checkOutput("tuser", 32'(axis.tuser), 32'(q[0].user));
      checkOutput("tlast", 32'(axis.tlast), 32'(q[0].last));
    end
    checkOutput("frame_cnt", 32'(frame_cnt), 32'(16'(m_frames)));
    checkOutput("overflow", 32'(overflow), 32'(m_ovf));
    checkOutput("line_err", 32'(line_err), 32'(m_lerr));
    checkOutput("frame_err", 32'(frame_err), 32'(m_ferr));
  endtask

  // One clock: drive strobes, let the edge happen, advance the model, check.
  task automatic applyStimulus(input logic vs, input logic hs);
    logic  rdy, ovf_now, lerr_now, ferr_now;
    beat_t b;
    VSYNC = vs;
    HSYNC = hs;
    case (rdy_mode)
      0:       rdy = 1'b1;
      1:       rdy = 1'($urandom_range(0, 1));
      default: rdy = 1'b0;
    endcase
    axis.tready = rdy;
    @(posedge clk);
    ovf_now  = 1'b0;
    lerr_now = 1'b0;
    ferr_now = 1'b0;
    if (rst) begin
      q.delete();
      pend_v = 1'b0; m_x = 0; m_line = 0; m_pat = 0; m_frames = 0;
      m_sof = 1'b0; m_ovf = 1'b0; m_lerr = 1'b0; m_ferr = 1'b0;
      m_vs_prev = 1'b0; m_hs_prev = 1'b0;
    end else begin
      if (!enable) begin
        q.delete();
        pend_v = 1'b0; m_sof = 1'b0; m_x = 0; m_line = 0;
      end else begin
        if (q.size() > 0 && rdy) void'(q.pop_front());
        if (pend_v) begin
          b = pend;
          b.last = !hs;
          if (q.size() < DEPTH) q.push_back(b);
          else ovf_now = 1'b1;
        end
        pend_v = 1'b0;
        if (vs && !m_vs_prev) begin
          m_frames++;
          m_sof  = 1'b1;
          m_pat  = int'(pat_sel);
          m_line = 0;
        end
        if (hs) begin
          pend.data = expPixel(m_pat, m_x, m_line, m_frames);
          pend.user = m_sof;
          pend_v    = 1'b1;
          m_sof     = 1'b0;
          m_x++;
        end
        if (!hs && m_hs_prev) begin
          lerr_now = (m_x != H);
          m_x = 0;
          m_line++;
        end
        if (!vs && m_vs_prev) ferr_now = (m_line != V);
      end
      m_ovf  = ovf_now  | (m_ovf  & !err_clr);
      m_lerr = lerr_now | (m_lerr & !err_clr);
      m_ferr = ferr_now | (m_ferr & !err_clr);
      m_vs_prev = vs;
      m_hs_prev = hs;
    end
    @(negedge clk);
    checkState();
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(cur_vs, 1'b0);
  endtask

  task automatic drawLine(input int n_px, input int gap);
    repeat (n_px) applyStimulus(cur_vs, 1'b1);
    repeat (gap) applyStimulus(cur_vs, 1'b0);
  endtask

  task automatic drawFrame(input int n_lines, input int n_px, input int gap);
    cur_vs = 1'b1;
    idle(2);
    repeat (n_lines) drawLine(n_px, gap);
    cur_vs = 1'b0;
    idle(3);
  endtask

  task automatic pulseClear();
    err_clr = 1'b1;
    idle(1);
    err_clr = 1'b0;
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; VSYNC = 1'b0; HSYNC = 1'b0; err_clr = 1'b0;
    pat_sel = 2'd0; axis.tready = 1'b1; rdy_mode = 0; cur_vs = 1'b0;
    pend_v = 1'b0; pend = '{1'b0, 1'b0, '0};
    m_x = 0; m_line = 0; m_pat = 0; m_frames = 0; m_sof = 1'b0;
    m_vs_prev = 1'b0; m_hs_prev = 1'b0; m_ovf = 1'b0; m_lerr = 1'b0; m_ferr = 1'b0;
    @(negedge clk);
    idle(3);
    checkOutput("rst_tdata", 32'(axis.tdata), 32'd0);
    checkOutput("rst_tuser", 32'(axis.tuser), 32'd0);
    checkOutput("rst_tlast", 32'(axis.tlast), 32'd0);
    rst = 1'b0;
    enable = 1'b1;

    $display("[TB] ramp frame, sink always ready");
    drawFrame(4, 8, 3);

    $display("[TB] sink stalled, FIFO overflow");
    rdy_mode = 2;
    cur_vs = 1'b1;
    idle(2);
    repeat (3) drawLine(8, 2);
    rdy_mode = 0;
    drawLine(8, 2);
    cur_vs = 1'b0;
    idle(24);
    checkOutput("t2_overflow", 32'(overflow), 32'd1);
    pulseClear();

    $display("[TB] short line");
    cur_vs = 1'b1;
    idle(2);
    drawLine(8, 3);
    drawLine(6, 3);
    checkOutput("t3_line_err", 32'(line_err), 32'd1);
    pulseClear();
    checkOutput("t3_clr", 32'(line_err), 32'd0);
    drawLine(8, 3);
    drawLine(8, 3);
    cur_vs = 1'b0;
    idle(3);

    $display("[TB] short frame");
    drawFrame(3, 8, 2);
    checkOutput("t4_frame_err", 32'(frame_err), 32'd1);
    drawFrame(4, 8, 2);
    pulseClear();

    $display("[TB] pattern change mid-frame");
    pat_sel = 2'd0;
    cur_vs = 1'b1;
    idle(2);
    drawLine(8, 2);
    pat_sel = 2'd3;
    repeat (3) drawLine(8, 2);
    cur_vs = 1'b0;
    idle(3);
    drawFrame(4, 8, 2);

    $display("[TB] reset and disable mid-line");
    cur_vs = 1'b1;
    idle(2);
    drawLine(3, 0);
    rst = 1'b1;
    cur_vs = 1'b0;
    applyStimulus(1'b0, 1'b0);
    rst = 1'b0;
    checkOutput("t6_rst_tvalid", 32'(axis.tvalid), 32'd0);
    idle(2);
    cur_vs = 1'b1;
    idle(2);
    drawLine(5, 2);
    drawLine(4, 0);
    enable = 1'b0;
    applyStimulus(1'b1, 1'b1);
    checkOutput("t6_dis_tvalid", 32'(axis.tvalid), 32'd0);
    cur_vs = 1'b0;
    idle(3);
    checkOutput("t6_lerr_kept", 32'(line_err), 32'd1);
    enable = 1'b1;
    idle(2);
    pulseClear();

    $display("[TB] random frames");
    rdy_mode = 1;
    for (int f = 0; f < 8; f++) begin
      pat_sel = 2'($urandom_range(0, 3));
      cur_vs = 1'b1;
      idle(int'($urandom_range(1, 3)));
      for (int l = 0, nl = int'($urandom_range(3, 5)); l < nl; l++) begin
        if ($urandom_range(0, 3) == 0) drawLine(int'($urandom_range(5, 20)), int'($urandom_range(1, 4)));
        else drawLine(H, int'($urandom_range(1, 4)));
      end
      cur_vs = 1'b0;
      idle(int'($urandom_range(2, 5)));
      if ($urandom_range(0, 1) == 1) pulseClear();
    end
    rdy_mode = 0;
    idle(24);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
